key_event_scheduler: RTL and testbench
======================================

Name: key_event_scheduler

Overview:
- Sits between the PS/2 keyboard decoder outputs (last_change, key_down, been_ready) and the calculator/control FSM.
- Turns raw decoder updates into a clean stream of classified key-press events: digits, +, -, *, Enter and Backspace.
- Queues the events in a small FIFO so several presses close together are serialized to the consumer over a valid/ready handshake.
- Replaces the per-key one-pulse generators with a single sequenced event source.

Parameters:
DEPTH, 4, FIFO entries; power of 2, 2..16
CNT_W, 3, width of ev_count; must satisfy 2^CNT_W > DEPTH

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk
last_change  input  9  most recent scan code from the decoder; bit 8 = E0 extended prefix
key_down  input  512  decoder held-key vector, indexed by {ext, code}
been_ready  input  1  one-cycle pulse: decoder updated last_change/key_down this cycle
ev_ready  input  1  consumer accepts head event this cycle
ovf_clr  input  1  clears the sticky overflow flag
ev_valid  output  1  FIFO non-empty; head event presented
ev_code  output  4  class of the head event
ev_raw  output  9  original scan code of the head event
ev_count  output  CNT_W  number of queued events
overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (rst=0 at a clk edge): FIFO emptied, pointers = 0, key_down_q = 0, all outputs = 0.
- key_down_q: 512-bit register, key_down delayed by one clk.
- Press detect in cycle T requires all of:
  - been_ready=1
  - key_down[last_change]=1
  - key_down_q[last_change]=0 (new press, not a typematic repeat)
  - last_change maps to a class
- Releases (key_down[last_change]=0) are never enqueued.
- Class map to ev_code:
  - digits 0-9 → codes 0-9:
    - top row 9'h045,016,01E,026,025,02E,036,03D,03E,046
    - keypad 9'h070,069,072,07A,06B,073,074,06C,075,07D
  - 9'h079 (+) → 10; 9'h07B (-) → 11; 9'h03A (M, multiply) → 12
  - 9'h05A or 9'h15A (Enter) → 13; 9'h066 (Backspace) → 14
  - all other codes: no event; 15 is never produced
- Push: the detected event {class, last_change} is written at the end of cycle T. If the FIFO was empty, ev_valid=1 at T+1 (1-cycle latency).
- Pop: occurs when ev_valid && ev_ready at a clk edge; the head advances on that edge. ev_ready while empty is ignored.
- Outputs come from registers or FIFO storage only; no combinational path from inputs to outputs.
- Full (ev_count==DEPTH):
  - push with no pop → event dropped, overflow set, FIFO contents unchanged
  - push and pop in the same cycle → both performed, no drop, count unchanged
- Empty: a simultaneous push and pop cannot occur, since pop requires ev_valid.
- Pointers wrap modulo DEPTH; ev_count = DEPTH distinguishes full from empty.
- overflow: cleared by ovf_clr=1. If a drop and ovf_clr occur in the same cycle, set wins (overflow=1).
- Ordering: strict FIFO; events leave in detection order.
- Reset mid-stream: queued events are discarded. key_down_q clears, so a key still held at reset release is detected as a new press on its next been_ready.

Optional Feature:
- Macro: KEY_EVENT_TYPEMATIC_EN
- Defined: the key_down_q[last_change]=0 condition is removed. Every been_ready with key_down[last_change]=1 and a mapped code enqueues an event, so held-key repeats produce repeated events.
- Undefined: one event per physical press, as in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then single press: last_change=9'h079, key_down[9'h079]=1, been_ready pulse at T, ev_ready=0 → at T+1 ev_valid=1, ev_code=10, ev_raw=9'h079, ev_count=1.
- Typematic filtering:
  - stimulus: press 9'h016, then three more been_ready pulses with key still held, then release
  - macro undefined → exactly one event, ev_code=1
  - macro defined → four events
- Release and unmapped: been_ready with key_down[9'h07B]=0, then a press of 9'h01C ('A') → ev_valid stays 0, ev_count stays 0.
- Overflow (DEPTH=4):
  - stimulus: ev_ready=0, five mapped presses (codes 1,2,3,4,5)
  - response: ev_count=4, overflow=1; drain yields 1,2,3,4
  - then ovf_clr=1 for one cycle → overflow=0
- Full with simultaneous push/pop: FIFO full, ev_ready=1 on the cycle a new Enter (9'h15A) is detected → ev_count stays 4, overflow stays 0, ev_code=13 appears last.
- Reset mid-operation: 3 events queued, rst=0 for one edge → ev_valid=0, ev_count=0, overflow=0; the next press is enqueued normally.

Source files
------------

// File: rtl/key_event_scheduler.sv
// key_event_scheduler: turns PS/2 decoder updates into classified key-press
// events and serializes them to the consumer through a small FIFO with a
// valid/ready handshake.
// Optional build macro: KEY_EVENT_TYPEMATIC_EN (held-key repeats also enqueue).
module key_event_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       last_change,
    input  logic [511:0]     key_down,
    input  logic             been_ready,
    input  logic             ev_ready,
    input  logic             ovf_clr,
    output logic             ev_valid,
    output logic [3:0]       ev_code,
    output logic [8:0]       ev_raw,
    output logic [CNT_W-1:0] ev_count,
    output logic             overflow
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned RAW_W  = 9;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [RAW_W-1:0]  raw;
    } ev_t;

    ev_t              mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             valid_q;
    logic             ovf_q;
    logic [511:0]     key_down_q;

    logic              map_hit;
    logic [CODE_W-1:0] map_code;
    logic              is_new;
    logic              press;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    // Scan code to event class; unmapped codes produce no event.
    always_comb begin
        map_hit  = 1'b1;
        map_code = '0;
        case (last_change)
            9'h045, 9'h070: map_code = 4'd0;
            9'h016, 9'h069: map_code = 4'd1;
            9'h01E, 9'h072: map_code = 4'd2;
            9'h026, 9'h07A: map_code = 4'd3;
            9'h025, 9'h06B: map_code = 4'd4;
            9'h02E, 9'h073: map_code = 4'd5;
            9'h036, 9'h074: map_code = 4'd6;
            9'h03D, 9'h06C: map_code = 4'd7;
            9'h03E, 9'h075: map_code = 4'd8;
            9'h046, 9'h07D: map_code = 4'd9;
            9'h079:         map_code = 4'd10;
            9'h07B:         map_code = 4'd11;
            9'h03A:         map_code = 4'd12;
            9'h05A, 9'h15A: map_code = 4'd13;
            9'h066:         map_code = 4'd14;
            default:        map_hit  = 1'b0;
        endcase
    end

`ifdef KEY_EVENT_TYPEMATIC_EN
    // Every decoder update of a held mapped key counts, including repeats.
    assign is_new = 1'b1;
`else
    // Only a key not already held last cycle counts as a press.
    assign is_new = ~key_down_q[last_change];
`endif

    assign press = been_ready & key_down[last_change] & is_new & map_hit;
    assign full  = (count == CNT_W'(DEPTH));
    assign pop   = valid_q & ev_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push  = press & (~full | pop);
    assign drop  = press & full & ~pop;

    // Occupancy after this edge.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO storage, pointers, occupancy, sticky overflow and key history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            key_down_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            key_down_q <= key_down;
            if (push) begin
                mem[wr_ptr] <= '{code: map_code, raw: last_change};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_nxt;
            valid_q <= (count_nxt != '0);
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Head event is presented straight from storage.
    assign ev_valid = valid_q;
    assign ev_code  = mem[rd_ptr].code;
    assign ev_raw   = mem[rd_ptr].raw;
    assign ev_count = count;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed vector bench for key_event_scheduler (DEPTH=4, CNT_W=3).
module tb_key_event_scheduler;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;
    localparam int KN = 0;   // key_down unchanged
    localparam int KS = 1;   // set key_down[lc]
    localparam int KC = 2;   // clear key_down[lc]
`ifdef KEY_EVENT_TYPEMATIC_EN
    localparam bit TM = 1'b1;
`else
    localparam bit TM = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [8:0]       last_change;
    logic [511:0]     key_down;
    logic             been_ready;
    logic             ev_ready;
    logic             ovf_clr;
    logic             ev_valid;
    logic [3:0]       ev_code;
    logic [8:0]       ev_raw;
    logic [CNT_W-1:0] ev_count;
    logic             overflow;

    int n_vec = 0;
    int n_bad = 0;

    key_event_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .last_change (last_change),
        .key_down    (key_down),
        .been_ready  (been_ready),
        .ev_ready    (ev_ready),
        .ovf_clr     (ovf_clr),
        .ev_valid    (ev_valid),
        .ev_code     (ev_code),
        .ev_raw      (ev_raw),
        .ev_count    (ev_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         rst;
        logic [8:0] lc;
        int         kd_op;
        bit         br;
        bit         rdy;
        bit         clr;
        bit         e_valid;
        logic [3:0] e_code;
        logic [8:0] e_raw;
        int         e_count;
        bit         e_ovf;
    } vec_t;

    function automatic vec_t mk(input string name, input bit r, input logic [8:0] lc,
                                input int op, input bit br, input bit rdy, input bit clr,
                                input bit v, input logic [3:0] code, input logic [8:0] raw,
                                input int cnt, input bit ovf);
        vec_t t;
        t.name = name; t.rst = r; t.lc = lc; t.kd_op = op; t.br = br; t.rdy = rdy;
        t.clr = clr; t.e_valid = v; t.e_code = code; t.e_raw = raw; t.e_count = cnt;
        t.e_ovf = ovf;
        return t;
    endfunction

    // Drive one cycle of inputs, let one edge pass, then compare outputs.
    task automatic apply(input vec_t v);
        bit bad;
        rst         = v.rst;
        last_change = v.lc;
        if (v.kd_op == KS) key_down[v.lc] = 1'b1;
        else if (v.kd_op == KC) key_down[v.lc] = 1'b0;
        been_ready  = v.br;
        ev_ready    = v.rdy;
        ovf_clr     = v.clr;
        @(posedge clk);
        #1;
        rst        = 1'b1;
        been_ready = 1'b0;
        ev_ready   = 1'b0;
        ovf_clr    = 1'b0;
        bad = (ev_valid !== v.e_valid) || (ev_count !== CNT_W'(v.e_count)) ||
              (overflow !== v.e_ovf);
        if (v.e_valid || !v.rst)
            bad = bad || (ev_code !== v.e_code) || (ev_raw !== v.e_raw);
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b code=%0d raw=%h count=%0d ovf=%0b, want valid=%0b code=%0d raw=%h count=%0d ovf=%0b",
                     v.name, ev_valid, ev_code, ev_raw, ev_count, overflow,
                     v.e_valid, v.e_code, v.e_raw, v.e_count, v.e_ovf);
        end
    endtask

    vec_t tbl[$];

    initial begin
        int n_ev;
        rst = 1'b0; last_change = '0; key_down = '0;
        been_ready = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;

        //                 name        rst lc      op br rdy clr  v code raw   cnt ovf
        tbl.push_back(mk("reset",      0, 9'h000, KN, 0, 0, 0,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("idle",       1, 9'h000, KN, 0, 0, 0,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("plus",       1, 9'h079, KS, 1, 0, 0,   1, 10, 9'h079, 1, 0));
        tbl.push_back(mk("plus_hold",  1, 9'h079, KN, 0, 0, 0,   1, 10, 9'h079, 1, 0));
        tbl.push_back(mk("plus_pop",   1, 9'h079, KN, 0, 1, 0,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("plus_rel",   1, 9'h079, KC, 1, 0, 0,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("minus_rel",  1, 9'h07B, KC, 1, 0, 0,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("a_press",    1, 9'h01C, KS, 1, 0, 0,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("a_rel",      1, 9'h01C, KC, 1, 0, 0,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("rdy_empty",  1, 9'h000, KN, 0, 1, 0,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("kp0",        1, 9'h070, KS, 1, 0, 0,   1, 0,  9'h070, 1, 0));
        tbl.push_back(mk("enter_ext",  1, 9'h15A, KS, 1, 0, 0,   1, 0,  9'h070, 2, 0));
        tbl.push_back(mk("bksp_pop",   1, 9'h066, KS, 1, 1, 0,   1, 13, 9'h15A, 2, 0));
        tbl.push_back(mk("pop_enter",  1, 9'h000, KN, 0, 1, 0,   1, 14, 9'h066, 1, 0));
        tbl.push_back(mk("pop_bksp",   1, 9'h000, KN, 0, 1, 0,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("minus",      1, 9'h07B, KS, 1, 0, 0,   1, 11, 9'h07B, 1, 0));
        tbl.push_back(mk("mult_pop",   1, 9'h03A, KS, 1, 1, 0,   1, 12, 9'h03A, 1, 0));
        tbl.push_back(mk("pop_mult",   1, 9'h000, KN, 0, 1, 0,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("ov1",        1, 9'h016, KS, 1, 0, 0,   1, 1,  9'h016, 1, 0));
        tbl.push_back(mk("ov2",        1, 9'h01E, KS, 1, 0, 0,   1, 1,  9'h016, 2, 0));
        tbl.push_back(mk("ov3",        1, 9'h026, KS, 1, 0, 0,   1, 1,  9'h016, 3, 0));
        tbl.push_back(mk("ov4",        1, 9'h025, KS, 1, 0, 0,   1, 1,  9'h016, 4, 0));
        tbl.push_back(mk("ov5_drop",   1, 9'h02E, KS, 1, 0, 0,   1, 1,  9'h016, 4, 1));
        tbl.push_back(mk("ov_hold",    1, 9'h000, KN, 0, 0, 0,   1, 1,  9'h016, 4, 1));
        tbl.push_back(mk("drain1",     1, 9'h000, KN, 0, 1, 0,   1, 2,  9'h01E, 3, 1));
        tbl.push_back(mk("drain2",     1, 9'h000, KN, 0, 1, 0,   1, 3,  9'h026, 2, 1));
        tbl.push_back(mk("drain3",     1, 9'h000, KN, 0, 1, 0,   1, 4,  9'h025, 1, 1));
        tbl.push_back(mk("drain4",     1, 9'h000, KN, 0, 1, 0,   0, 0,  9'h000, 0, 1));
        tbl.push_back(mk("ovf_clr",    1, 9'h000, KN, 0, 0, 1,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("f6",         1, 9'h036, KS, 1, 0, 0,   1, 6,  9'h036, 1, 0));
        tbl.push_back(mk("f7",         1, 9'h03D, KS, 1, 0, 0,   1, 6,  9'h036, 2, 0));
        tbl.push_back(mk("f8",         1, 9'h03E, KS, 1, 0, 0,   1, 6,  9'h036, 3, 0));
        tbl.push_back(mk("f9",         1, 9'h046, KS, 1, 0, 0,   1, 6,  9'h036, 4, 0));
        tbl.push_back(mk("enter_rel",  1, 9'h15A, KC, 1, 0, 0,   1, 6,  9'h036, 4, 0));
        tbl.push_back(mk("full_pushpop",1,9'h15A, KS, 1, 1, 0,   1, 7,  9'h03D, 4, 0));
        tbl.push_back(mk("fd8",        1, 9'h000, KN, 0, 1, 0,   1, 8,  9'h03E, 3, 0));
        tbl.push_back(mk("fd9",        1, 9'h000, KN, 0, 1, 0,   1, 9,  9'h046, 2, 0));
        tbl.push_back(mk("fd13",       1, 9'h000, KN, 0, 1, 0,   1, 13, 9'h15A, 1, 0));
        tbl.push_back(mk("fd_empty",   1, 9'h000, KN, 0, 1, 0,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("k1",         1, 9'h069, KS, 1, 0, 0,   1, 1,  9'h069, 1, 0));
        tbl.push_back(mk("k2",         1, 9'h072, KS, 1, 0, 0,   1, 1,  9'h069, 2, 0));
        tbl.push_back(mk("k3",         1, 9'h07A, KS, 1, 0, 0,   1, 1,  9'h069, 3, 0));
        tbl.push_back(mk("k4",         1, 9'h06B, KS, 1, 0, 0,   1, 1,  9'h069, 4, 0));
        tbl.push_back(mk("drop_and_clr",1,9'h073, KS, 1, 0, 1,   1, 1,  9'h069, 4, 1));
        tbl.push_back(mk("clr_after",  1, 9'h000, KN, 0, 0, 1,   1, 1,  9'h069, 4, 0));
        tbl.push_back(mk("pop_to3",    1, 9'h000, KN, 0, 1, 0,   1, 2,  9'h072, 3, 0));
        tbl.push_back(mk("mid_reset",  0, 9'h000, KN, 0, 0, 0,   0, 0,  9'h000, 0, 0));
        tbl.push_back(mk("held_repress",1,9'h073, KN, 1, 0, 0,   1, 5,  9'h073, 1, 0));
        tbl.push_back(mk("kp6_after",  1, 9'h074, KS, 1, 0, 0,   1, 5,  9'h073, 2, 0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i]);

        // Held-key repeats: one event per press, or one per update with typematic on.
        apply(mk("tm_reset",   0, 9'h000, KN, 0, 0, 0, 0, 0, 9'h000, 0, 0));
        apply(mk("tm_rel_016", 1, 9'h016, KC, 1, 0, 0, 0, 0, 9'h000, 0, 0));
        apply(mk("tm_press",   1, 9'h016, KS, 1, 0, 0, 1, 1, 9'h016, 1, 0));
        for (int r = 1; r <= 3; r++) begin
            n_ev = TM ? 1 + r : 1;
            apply(mk($sformatf("tm_repeat%0d", r), 1, 9'h016, KN, 1, 0, 0, 1, 1, 9'h016, n_ev, 0));
        end
        n_ev = TM ? 4 : 1;
        apply(mk("tm_release", 1, 9'h016, KC, 1, 0, 0, 1, 1, 9'h016, n_ev, 0));
        for (int k = n_ev - 1; k >= 0; k--) begin
            apply(mk($sformatf("tm_drain%0d", k), 1, 9'h000, KN, 0, 1, 0,
                     (k > 0), (k > 0) ? 4'd1 : 4'd0, (k > 0) ? 9'h016 : 9'h000, k, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
